// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer, flush and bubble-gated control.
// Define PIPE_STAGE_STATS_EN to build the saturating stall/bubble counters; otherwise they read 0.
module pipe_stage_elastic #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned DST_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DST_W-1:0]  dst_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DST_W-1:0]  dst_o,
    output logic [1:0]        count_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam int unsigned PAY_W = DATA_W + CTRL_W + DST_W;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       countQ, countD;
    logic [PAY_W-1:0] headQ, headD;
    logic [PAY_W-1:0] skidQ, skidD;
    logic [PAY_W-1:0] inBeat;
    logic             accept, emit;

    assign inBeat  = {data_i, ctrl_i, dst_i};
    assign ready_o = (countQ != FULL);
    assign valid_o = (countQ != EMPTY);
    assign accept  = valid_i & ready_o;
    assign emit    = valid_o & ready_i;
    assign count_o = countQ;

    assign data_o = headQ[PAY_W-1 -: DATA_W];
    assign ctrl_o = valid_o ? headQ[DST_W +: CTRL_W] : '0;
    assign dst_o  = headQ[DST_W-1:0];

    always_comb begin
        countD = countQ;
        headD  = headQ;
        skidD  = skidQ;
        case (countQ)
            EMPTY: begin
                if (accept) begin
                    countD = ONE;
                    headD  = inBeat;
                end
            end
            ONE: begin
                if (accept && !emit) begin
                    countD = FULL;
                    skidD  = inBeat;
                end else if (accept && emit) begin
                    headD  = inBeat;
                end else if (emit) begin
                    countD = EMPTY;
                end
            end
            FULL: begin
                if (emit) begin
                    countD = ONE;
                    headD  = skidQ;
                end
            end
            default: countD = EMPTY;
        endcase
        // Flush drops occupancy only; payload registers keep their contents.
        if (flush_i) begin
            countD = EMPTY;
            headD  = headQ;
            skidD  = skidQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            countQ <= EMPTY;
            headQ  <= '0;
            skidQ  <= '0;
        end else begin
            countQ <= countD;
            headQ  <= headD;
            skidQ  <= skidD;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stallCntQ, bubbleCntQ;

    // Counters saturate and survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            stallCntQ  <= '0;
            bubbleCntQ <= '0;
        end else begin
            if (valid_o && !ready_i && (stallCntQ != '1)) begin
                stallCntQ <= stallCntQ + CNT_W'(1);
            end
            if (!valid_o && (bubbleCntQ != '1)) begin
                bubbleCntQ <= bubbleCntQ + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o  = stallCntQ;
    assign bubble_cnt_o = bubbleCntQ;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed, table-driven bench for pipe_stage_elastic plus a hand-written statistics sequence.
module tb_pipe_stage_elastic;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CTRL_W = 2;
    localparam int unsigned DST_W  = 5;
    localparam int unsigned CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              flush_i = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [DATA_W-1:0] data_i = '0;
    logic [CTRL_W-1:0] ctrl_i = '0;
    logic [DST_W-1:0]  dst_i = '0;
    logic              valid_o;
    logic              ready_i = 1'b0;
    logic [DATA_W-1:0] data_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DST_W-1:0]  dst_o;
    logic [1:0]        count_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .DST_W (DST_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .ctrl_i      (ctrl_i),
        .dst_i       (dst_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .ctrl_o      (ctrl_o),
        .dst_o       (dst_o),
        .count_o     (count_o),
        .stall_cnt_o (stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        vin;
        logic        rdy;
        logic [63:0] data;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        eValid;
        logic        eReady;
        logic [1:0]  eCount;
        logic [63:0] eData;
        logic [1:0]  eCtrl;
        logic [4:0]  eDst;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic r, logic f, logic v, logic rd, logic [63:0] d,
                                logic [1:0] c, logic [4:0] ds, logic ev, logic er,
                                logic [1:0] ecnt, logic [63:0] ed, logic [1:0] ec,
                                logic [4:0] eds);
        vec_t t;
        t.rst = r;      t.flush = f;     t.vin = v;       t.rdy = rd;
        t.data = d;     t.ctrl = c;      t.dst = ds;
        t.eValid = ev;  t.eReady = er;   t.eCount = ecnt;
        t.eData = ed;   t.eCtrl = ec;    t.eDst = eds;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic f, input logic v, input logic rd,
                         input logic [63:0] d, input logic [1:0] c, input logic [4:0] ds);
        rst_i = r; flush_i = f; valid_i = v; ready_i = rd;
        data_i = d; ctrl_i = c; dst_i = ds;
    endtask

    initial begin
        // rst flush vin rdy data ctrl dst | valid ready count data ctrl dst (state after the edge)
        vecs.push_back(mk(1, 0, 0, 0, 64'h0,  2'd0, 5'd0,  0, 1, 0, 64'h0,  2'd0, 5'd0));
        vecs.push_back(mk(1, 0, 0, 0, 64'h0,  2'd0, 5'd0,  0, 1, 0, 64'h0,  2'd0, 5'd0));
        // back-to-back streaming
        vecs.push_back(mk(0, 0, 1, 1, 64'h10, 2'd3, 5'h10, 1, 1, 1, 64'h10, 2'd3, 5'h10));
        vecs.push_back(mk(0, 0, 1, 1, 64'h11, 2'd3, 5'h11, 1, 1, 1, 64'h11, 2'd3, 5'h11));
        vecs.push_back(mk(0, 0, 1, 1, 64'h12, 2'd3, 5'h12, 1, 1, 1, 64'h12, 2'd3, 5'h12));
        vecs.push_back(mk(0, 0, 1, 1, 64'h13, 2'd3, 5'h13, 1, 1, 1, 64'h13, 2'd3, 5'h13));
        vecs.push_back(mk(0, 0, 0, 1, 64'h0,  2'd0, 5'd0,  0, 1, 0, 64'h13, 2'd0, 5'h13));
        // backpressure fills skid, C held off, then drained in order
        vecs.push_back(mk(0, 0, 1, 0, 64'hA,  2'd3, 5'hA,  1, 1, 1, 64'hA,  2'd3, 5'hA));
        vecs.push_back(mk(0, 0, 1, 0, 64'hB,  2'd3, 5'hB,  1, 0, 2, 64'hA,  2'd3, 5'hA));
        vecs.push_back(mk(0, 0, 1, 0, 64'hC,  2'd3, 5'hC,  1, 0, 2, 64'hA,  2'd3, 5'hA));
        vecs.push_back(mk(0, 0, 1, 1, 64'hC,  2'd3, 5'hC,  1, 1, 1, 64'hB,  2'd3, 5'hB));
        vecs.push_back(mk(0, 0, 1, 1, 64'hC,  2'd3, 5'hC,  1, 1, 1, 64'hC,  2'd3, 5'hC));
        vecs.push_back(mk(0, 0, 0, 1, 64'h0,  2'd0, 5'd0,  0, 1, 0, 64'hC,  2'd0, 5'hC));
        // flush while full with a beat offered
        vecs.push_back(mk(0, 0, 1, 0, 64'hE1, 2'd3, 5'd1,  1, 1, 1, 64'hE1, 2'd3, 5'd1));
        vecs.push_back(mk(0, 0, 1, 0, 64'hE2, 2'd3, 5'd2,  1, 0, 2, 64'hE1, 2'd3, 5'd1));
        vecs.push_back(mk(0, 1, 1, 0, 64'hD,  2'd3, 5'hD,  0, 1, 0, 64'hE1, 2'd0, 5'd1));
        vecs.push_back(mk(0, 0, 0, 1, 64'h0,  2'd0, 5'd0,  0, 1, 0, 64'hE1, 2'd0, 5'd1));
        // control gating on bubbles
        vecs.push_back(mk(0, 0, 1, 1, 64'h5,  2'd1, 5'd5,  1, 1, 1, 64'h5,  2'd1, 5'd5));
        vecs.push_back(mk(0, 0, 0, 1, 64'h0,  2'd0, 5'd0,  0, 1, 0, 64'h5,  2'd0, 5'd5));
        vecs.push_back(mk(0, 0, 0, 1, 64'h0,  2'd0, 5'd0,  0, 1, 0, 64'h5,  2'd0, 5'd5));
        // reset mid-stream overrides an active handshake
        vecs.push_back(mk(0, 0, 1, 0, 64'h20, 2'd3, 5'd7,  1, 1, 1, 64'h20, 2'd3, 5'd7));
        vecs.push_back(mk(0, 0, 1, 0, 64'h21, 2'd3, 5'd8,  1, 0, 2, 64'h20, 2'd3, 5'd7));
        vecs.push_back(mk(1, 0, 1, 1, 64'h22, 2'd3, 5'd9,  0, 1, 0, 64'h0,  2'd0, 5'd0));
        vecs.push_back(mk(1, 1, 1, 1, 64'h22, 2'd3, 5'd9,  0, 1, 0, 64'h0,  2'd0, 5'd0));
        vecs.push_back(mk(0, 0, 0, 1, 64'h0,  2'd0, 5'd0,  0, 1, 0, 64'h0,  2'd0, 5'd0));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].vin, vecs[i].rdy,
                  vecs[i].data, vecs[i].ctrl, vecs[i].dst);
            step();
            chk($sformatf("v%0d valid_o", i), 64'(valid_o), 64'(vecs[i].eValid));
            chk($sformatf("v%0d ready_o", i), 64'(ready_o), 64'(vecs[i].eReady));
            chk($sformatf("v%0d count_o", i), 64'(count_o), 64'(vecs[i].eCount));
            chk($sformatf("v%0d data_o", i),  64'(data_o),  vecs[i].eData);
            chk($sformatf("v%0d ctrl_o", i),  64'(ctrl_o),  64'(vecs[i].eCtrl));
            chk($sformatf("v%0d dst_o", i),   64'(dst_o),   64'(vecs[i].eDst));
        end

        // Statistics: reset, two idle cycles, one accept, then ten stalled cycles.
        drive(1, 0, 0, 0, 64'h0, 2'd0, 5'd0);
        step();
        chk("stats reset stall", 64'(stall_cnt_o), 64'd0);
        chk("stats reset bubble", 64'(bubble_cnt_o), 64'd0);
        drive(0, 0, 0, 0, 64'h0, 2'd0, 5'd0);
        step();
        step();
`ifdef PIPE_STAGE_STATS_EN
        chk("bubble after idle", 64'(bubble_cnt_o), 64'd2);
`else
        chk("bubble after idle", 64'(bubble_cnt_o), 64'd0);
`endif
        drive(0, 0, 1, 0, 64'h77, 2'd1, 5'd3);
        step();
        drive(0, 0, 0, 0, 64'h0, 2'd0, 5'd0);
        for (int i = 0; i < 10; i++) begin
            step();
        end
        chk("stall hold valid", 64'(valid_o), 64'd1);
        chk("stall hold data", 64'(data_o), 64'h77);
`ifdef PIPE_STAGE_STATS_EN
        chk("stall saturated", 64'(stall_cnt_o), 64'd7);
        chk("bubble after stall", 64'(bubble_cnt_o), 64'd3);
`else
        chk("stall saturated", 64'(stall_cnt_o), 64'd0);
        chk("bubble after stall", 64'(bubble_cnt_o), 64'd0);
`endif
        // Flush must not clear the statistics.
        drive(0, 1, 0, 0, 64'h0, 2'd0, 5'd0);
        step();
        chk("flush valid", 64'(valid_o), 64'd0);
`ifdef PIPE_STAGE_STATS_EN
        chk("stall after flush", 64'(stall_cnt_o), 64'd7);
`else
        chk("stall after flush", 64'(stall_cnt_o), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
